// File: rtl/hms_counter.sv
// BCD hours/minutes/seconds keeper with a one-second prescaler, adjust pulses and a colour offset.
// Build option: define HMS_12H_EN for a 12-hour (12, 01..11) hours field; default is 24-hour.
module hms_counter #(
   parameter int unsigned TICKS_PER_SEC = 31_500_000,
   parameter int unsigned PRESC_W       = $clog2(TICKS_PER_SEC)
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       adj_sec,
   input  logic       adj_min,
   input  logic       adj_hrs,
   output logic [3:0] sec_u,
   output logic [2:0] sec_d,
   output logic [3:0] min_u,
   output logic [2:0] min_d,
   output logic [3:0] hrs_u,
   output logic [1:0] hrs_d,
   output logic [3:0] color_offset,
   output logic       sec_tick
);

   localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICKS_PER_SEC - 1);
`ifdef HMS_12H_EN
   localparam logic [1:0] HRS_D_RST = 2'd1;
   localparam logic [3:0] HRS_U_RST = 4'd2;
`else
   localparam logic [1:0] HRS_D_RST = 2'd0;
   localparam logic [3:0] HRS_U_RST = 4'd0;
`endif

   logic [PRESC_W-1:0] presc, presc_nxt;
   logic               t, sec_last, min_last, cs, cm, inc_s, inc_m, inc_h;
   logic [3:0]         sec_u_nxt, min_u_nxt, hrs_u_nxt, color_nxt;
   logic [2:0]         sec_d_nxt, min_d_nxt;
   logic [1:0]         hrs_d_nxt;

   // Carries come only from the tick; adjust pulses wrap inside their own field.
   always_comb begin
      t         = (presc == PRESC_MAX);
      sec_last  = (sec_d == 3'd5) && (sec_u == 4'd9);
      min_last  = (min_d == 3'd5) && (min_u == 4'd9);
      cs        = t && sec_last;
      cm        = cs && min_last;
      inc_s     = t || adj_sec;
      inc_m     = cs || adj_min;
      inc_h     = cm || adj_hrs;
      presc_nxt = t ? '0 : presc + PRESC_W'(1);
      sec_u_nxt = sec_u;
      sec_d_nxt = sec_d;
      min_u_nxt = min_u;
      min_d_nxt = min_d;
      hrs_u_nxt = hrs_u;
      hrs_d_nxt = hrs_d;
      color_nxt = inc_m ? color_offset + 4'd1 : color_offset;

      if (inc_s) begin
         if (sec_u == 4'd9) begin
            sec_u_nxt = 4'd0;
            sec_d_nxt = sec_last ? 3'd0 : sec_d + 3'd1;
         end else begin
            sec_u_nxt = sec_u + 4'd1;
         end
      end

      if (inc_m) begin
         if (min_u == 4'd9) begin
            min_u_nxt = 4'd0;
            min_d_nxt = min_last ? 3'd0 : min_d + 3'd1;
         end else begin
            min_u_nxt = min_u + 4'd1;
         end
      end

      if (inc_h) begin
`ifdef HMS_12H_EN
         if (hrs_d == 2'd1 && hrs_u == 4'd2) begin
            hrs_d_nxt = 2'd0;
            hrs_u_nxt = 4'd1;
         end else if (hrs_u == 4'd9) begin
            hrs_d_nxt = 2'd1;
            hrs_u_nxt = 4'd0;
         end else begin
            hrs_u_nxt = hrs_u + 4'd1;
         end
`else
         if (hrs_d == 2'd2 && hrs_u == 4'd3) begin
            hrs_d_nxt = 2'd0;
            hrs_u_nxt = 4'd0;
         end else if (hrs_u == 4'd9) begin
            hrs_d_nxt = hrs_d + 2'd1;
            hrs_u_nxt = 4'd0;
         end else begin
            hrs_u_nxt = hrs_u + 4'd1;
         end
`endif
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         presc        <= '0;
         sec_tick     <= 1'b0;
         color_offset <= 4'd0;
         sec_u        <= 4'd0;
         sec_d        <= 3'd0;
         min_u        <= 4'd0;
         min_d        <= 3'd0;
         hrs_u        <= HRS_U_RST;
         hrs_d        <= HRS_D_RST;
      end else begin
         presc        <= presc_nxt;
         sec_tick     <= t;
         color_offset <= color_nxt;
         sec_u        <= sec_u_nxt;
         sec_d        <= sec_d_nxt;
         min_u        <= min_u_nxt;
         min_d        <= min_d_nxt;
         hrs_u        <= hrs_u_nxt;
         hrs_d        <= hrs_d_nxt;
      end
   end

endmodule

// File: tb/tb_hms_counter.sv
// Directed bench for hms_counter with a 4-cycle second; works with or without HMS_12H_EN.
module tb_hms_counter;

`ifdef HMS_12H_EN
   localparam int H0    = 12;
   localparam int H_PRE = 11;
`else
   localparam int H0    = 0;
   localparam int H_PRE = 23;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       adj_sec = 1'b0;
   logic       adj_min = 1'b0;
   logic       adj_hrs = 1'b0;
   logic [3:0] sec_u, min_u, hrs_u, color_offset;
   logic [2:0] sec_d, min_d;
   logic [1:0] hrs_d;
   logic       sec_tick;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   hms_counter #(.TICKS_PER_SEC(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .adj_sec      (adj_sec),
      .adj_min      (adj_min),
      .adj_hrs      (adj_hrs),
      .sec_u        (sec_u),
      .sec_d        (sec_d),
      .min_u        (min_u),
      .min_d        (min_d),
      .hrs_u        (hrs_u),
      .hrs_d        (hrs_d),
      .color_offset (color_offset),
      .sec_tick     (sec_tick)
   );

   task automatic check(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
   endtask

   function automatic int hrs();
      return int'(hrs_d) * 10 + int'(hrs_u);
   endfunction

   function automatic int tod();
      return hrs() * 10000 + (int'(min_d) * 10 + int'(min_u)) * 100
             + int'(sec_d) * 10 + int'(sec_u);
   endfunction

   function automatic int in_range();
      logic ok;
      ok = (sec_u <= 4'd9) && (sec_d <= 3'd5) && (min_u <= 4'd9) &&
           (min_d <= 3'd5) && (hrs_u <= 4'd9);
`ifdef HMS_12H_EN
      ok = ok && (hrs() >= 1) && (hrs() <= 12);
`else
      ok = ok && (hrs() <= 23);
`endif
      return int'(ok);
   endfunction

   // Every sampled cycle outside reset must show legal digits.
   always @(negedge clk) if (!reset) check("range", in_range(), 1);

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic drive(input logic s, input logic m, input logic h);
      adj_sec = s;
      adj_min = m;
      adj_hrs = h;
   endtask

   initial begin
      @(negedge clk);
      check("rst_tod", tod(), H0 * 10000);
      check("rst_col", int'(color_offset), 0);
      check("rst_tick", int'(sec_tick), 0);
      reset = 1'b0;

      // Tick period
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         check("tick", int'(sec_tick), int'(k % 4 == 0));
         check("tick_tod", tod(), H0 * 10000 + k / 4);
      end

      // Preload to 23:59:59 (11:59:59) just before a tick, then roll over
      do_reset();
      for (int k = 1; k <= 59; k++) begin
         drive(1'b1, 1'b1, k <= 23);
         @(negedge clk);
      end
      drive(1'b0, 1'b0, 1'b0);
      check("preload", tod(), H_PRE * 10000 + 5959);
      check("preload_col", int'(color_offset), 11);
      @(negedge clk);
      check("rollover", tod(), H0 * 10000);
      check("rollover_col", int'(color_offset), 12);
      check("rollover_tick", int'(sec_tick), 1);

      // adj_sec at :59 with t low
      @(negedge clk);
      for (int k = 0; k < 59; k++) begin
         drive(1'b1, 1'b0, 1'b0);
         @(negedge clk);
      end
      drive(1'b0, 1'b0, 1'b0);
      check("sec59", tod(), H0 * 10000 + 59);
      drive(1'b1, 1'b0, 1'b0);
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0);
      check("adj_sec_wrap", tod(), H0 * 10000);
      check("adj_sec_col", int'(color_offset), 12);

      // adj_min at minute 59
      for (int k = 0; k < 59; k++) begin
         drive(1'b0, 1'b1, 1'b0);
         @(negedge clk);
      end
      drive(1'b0, 1'b0, 1'b0);
      check("min59", tod(), H0 * 10000 + 5915);
      check("min59_col", int'(color_offset), 7);
      drive(1'b0, 1'b1, 1'b0);
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0);
      check("adj_min_wrap", tod(), H0 * 10000 + 15);
      check("adj_min_col", int'(color_offset), 8);

      // adj_sec coincident with t at :59
      repeat (2) @(negedge clk);
      for (int k = 0; k < 44; k++) begin
         drive(1'b1, 1'b0, 1'b0);
         @(negedge clk);
      end
      drive(1'b0, 1'b0, 1'b0);
      check("sim_pre", tod(), H0 * 10000 + 59);
      drive(1'b1, 1'b0, 1'b0);
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0);
      check("sim_sec", tod(), H0 * 10000 + 100);
      check("sim_sec_col", int'(color_offset), 9);
      check("sim_sec_tick", int'(sec_tick), 1);

      // adj_min coincident with cs
      for (int k = 0; k < 59; k++) begin
         drive(1'b1, 1'b0, 1'b0);
         @(negedge clk);
      end
      drive(1'b0, 1'b0, 1'b0);
      check("sim_min_pre", tod(), H0 * 10000 + 159);
      drive(1'b0, 1'b1, 1'b0);
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0);
      check("sim_min", tod(), H0 * 10000 + 200);
      check("sim_min_col", int'(color_offset), 10);

      // Reset at 05:37:42 with the prescaler at 2
      do_reset();
      for (int k = 1; k <= 42; k++) begin
         drive(1'b1, k <= 37, k <= 5);
         @(negedge clk);
      end
      drive(1'b0, 1'b0, 1'b0);
      check("mid_tod", tod(), 53742);
      check("mid_col", int'(color_offset), 37 % 16);
      #2 reset = 1'b1;
      #1;
      check("async_tod", tod(), H0 * 10000);
      check("async_col", int'(color_offset), 0);
      check("async_tick", int'(sec_tick), 0);
      @(negedge clk);
      reset = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         check("post_rst_tick", int'(sec_tick), int'(k == 4));
         check("post_rst_tod", tod(), H0 * 10000 + int'(k == 4));
      end

      // Hours-only sweep through the wrap
      do_reset();
      for (int k = 1; k <= 24; k++) begin
         adj_hrs = 1'b1;
         @(negedge clk);
         adj_hrs = 1'b0;
`ifdef HMS_12H_EN
         check("hrs_step", hrs(), ((k - 1) % 12) + 1);
`else
         check("hrs_step", hrs(), k % 24);
`endif
         @(negedge clk);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
